crc_checker_strip: RTL

- Receive-side counterpart of the team's byte-enable CRC generator.
- Takes a word stream whose frames end in an appended FCS (CRC_BYTES bytes, MSB byte first).
- Checks the FCS by the zero-residue test, strips the FCS from the stream and forwards the payload.
- Reports a per-frame status pulse aligned with the last payload word.
- Sits between the deserialiser/framer and the payload consumer.

---
 rtl/crc_checker_strip.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/crc_checker_strip.sv
// crc_checker_strip: receive-side FCS checker. It runs a parallel CRC over every
// received byte, FCS included, and tests for a zero residue on the last word.
// The FCS bytes are removed from the stream and only the payload is forwarded.
// A one-cycle status strobe comes out with the last payload word. For a frame
// with no payload bytes (a runt), the status strobe comes out on its own.
module crc_checker_strip #(
  parameter int unsigned           BYTES_NUM  = 4,
  parameter int unsigned           CRC_DEGREE = 32,
  parameter logic [CRC_DEGREE-1:0] POLY       = CRC_DEGREE'(32'h04C1_1DB7)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BYTES_NUM-1:0][7:0] data_in,
  input  logic [BYTES_NUM-1:0]      byte_vld,
  input  logic                      data_vld,
  input  logic                      last_word,
  output logic [BYTES_NUM-1:0][7:0] data_out,
  output logic [BYTES_NUM-1:0]      byte_vld_out,
  output logic                      data_vld_out,
  output logic                      last_word_out,
  output logic                      status_vld,
  output logic                      crc_ok,
  output logic                      runt
);

  localparam int unsigned CRC_BYTES = CRC_DEGREE / 8;

  typedef logic [BYTES_NUM-1:0][7:0] word_t;
  typedef logic [BYTES_NUM-1:0]      bv_t;
  typedef logic [CRC_DEGREE-1:0]     crc_t;

  // Count of enabled bytes in a word.
  function automatic int unsigned popcount(input bv_t bv);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < BYTES_NUM; i++) begin
      if (bv[i]) cnt++;
    end
    return cnt;
  endfunction

  // Enable mask that selects the n most significant (earliest) bytes.
  function automatic bv_t upper_mask(input int unsigned n);
    bv_t m;
    m = '0;
    for (int unsigned i = 0; i < BYTES_NUM; i++) begin
      m[i] = (i + n >= BYTES_NUM);
    end
    return m;
  endfunction

  // Drive the disabled bytes to zero.
  function automatic word_t apply_mask(input word_t w, input bv_t m);
    word_t r;
    r = '0;
    for (int unsigned i = 0; i < BYTES_NUM; i++) begin
      if (m[i]) r[i] = w[i];
    end
    return r;
  endfunction

  // Byte-parallel CRC update. Bytes are taken MSB byte first and MSB bit
  // first, and disabled bytes leave the register untouched.
  function automatic crc_t crc_update(input crc_t c, input word_t d, input bv_t en);
    crc_t r;
    logic fb;
    r = c;
    for (int unsigned i = 0; i < BYTES_NUM; i++) begin
      if (en[BYTES_NUM-1-i]) begin
        for (int unsigned b = 0; b < 8; b++) begin
          fb = r[CRC_DEGREE-1] ^ d[BYTES_NUM-1-i][7-b];
          r  = {r[CRC_DEGREE-2:0], 1'b0};
          if (fb) r = r ^ POLY;
        end
      end
    end
    return r;
  endfunction

  crc_t  crc_q, crc_d;
  word_t hold_q, hold_d;
  logic  hold_vld_q, hold_vld_d;
  word_t tail_q, tail_d;
  bv_t   tail_bv_q, tail_bv_d;
  logic  tail_vld_q, tail_vld_d;
  logic  tail_ok_q, tail_ok_d;
  logic  tail_runt_q, tail_runt_d;

  word_t out_data_q, out_data_d;
  bv_t   out_bv_q, out_bv_d;
  logic  out_vld_q, out_vld_d;
  logic  out_last_q, out_last_d;
  logic  out_st_q, out_st_d;
  logic  out_ok_q, out_ok_d;
  logic  out_runt_q, out_runt_d;

  bv_t         eff_bv;
  crc_t        crc_calc;
  logic        residue_ok;
  int unsigned k;
  int unsigned keep;

  // Next-state logic for the CRC, the hold and tail stages, and the output registers.
  always_comb begin
    eff_bv     = last_word ? byte_vld : '1;
    crc_calc   = crc_update(crc_q, data_in, eff_bv);
    residue_ok = (crc_calc == '0);
    k          = popcount(byte_vld);
    keep       = (k <= CRC_BYTES) ? (BYTES_NUM - CRC_BYTES + k) : BYTES_NUM;

    crc_d       = crc_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    tail_d      = '0;
    tail_bv_d   = '0;
    tail_vld_d  = 1'b0;
    tail_ok_d   = 1'b0;
    tail_runt_d = 1'b0;

    out_data_d = '0;
    out_bv_d   = '0;
    out_vld_d  = 1'b0;
    out_last_d = 1'b0;
    out_st_d   = 1'b0;
    out_ok_d   = 1'b0;
    out_runt_d = 1'b0;

    // The tail always drains, whether or not an input word is present.
    if (tail_vld_q) begin
      out_data_d = tail_q;
      out_bv_d   = tail_bv_q;
      out_vld_d  = !tail_runt_q;
      out_last_d = !tail_runt_q;
      out_st_d   = 1'b1;
      out_ok_d   = tail_ok_q;
      out_runt_d = tail_runt_q;
    end

    if (data_vld) begin
      crc_d = last_word ? '0 : crc_calc;
      if (!last_word) begin
        if (hold_vld_q) begin
          out_data_d = hold_q;
          out_bv_d   = '1;
          out_vld_d  = 1'b1;
        end
        hold_d     = data_in;
        hold_vld_d = 1'b1;
      end else begin
        hold_d     = '0;
        hold_vld_d = 1'b0;
        if (hold_vld_q) begin
          out_bv_d   = upper_mask(keep);
          out_data_d = apply_mask(hold_q, upper_mask(keep));
          out_vld_d  = 1'b1;
          if (k <= CRC_BYTES) begin
            out_last_d = 1'b1;
            out_st_d   = 1'b1;
            out_ok_d   = residue_ok;
          end else begin
            tail_bv_d  = upper_mask(k - CRC_BYTES);
            tail_d     = apply_mask(data_in, upper_mask(k - CRC_BYTES));
            tail_vld_d = 1'b1;
            tail_ok_d  = residue_ok;
          end
        end else if (k > CRC_BYTES) begin
          tail_bv_d  = upper_mask(k - CRC_BYTES);
          tail_d     = apply_mask(data_in, upper_mask(k - CRC_BYTES));
          tail_vld_d = 1'b1;
          tail_ok_d  = residue_ok;
        end else if (tail_vld_q) begin
          // A runt that arrives while the previous tail drains would collide with
          // that tail's status. The runt is queued in the tail and reported one cycle later.
          tail_vld_d  = 1'b1;
          tail_ok_d   = residue_ok;
          tail_runt_d = 1'b1;
        end else begin
          out_st_d   = 1'b1;
          out_ok_d   = residue_ok;
          out_runt_d = 1'b1;
        end
      end
    end
  end

  // State and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      tail_q      <= '0;
      tail_bv_q   <= '0;
      tail_vld_q  <= 1'b0;
      tail_ok_q   <= 1'b0;
      tail_runt_q <= 1'b0;
      out_data_q  <= '0;
      out_bv_q    <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_st_q    <= 1'b0;
      out_ok_q    <= 1'b0;
      out_runt_q  <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      tail_q      <= tail_d;
      tail_bv_q   <= tail_bv_d;
      tail_vld_q  <= tail_vld_d;
      tail_ok_q   <= tail_ok_d;
      tail_runt_q <= tail_runt_d;
      out_data_q  <= out_data_d;
      out_bv_q    <= out_bv_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_st_q    <= out_st_d;
      out_ok_q    <= out_ok_d;
      out_runt_q  <= out_runt_d;
    end
  end

  assign data_out      = out_data_q;
  assign byte_vld_out  = out_bv_q;
  assign data_vld_out  = out_vld_q;
  assign last_word_out = out_last_q;
  assign status_vld    = out_st_q;
  assign crc_ok        = out_ok_q;
  assign runt          = out_runt_q;

endmodule
